// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port 16-bit data memory between the cpu
// path (m0) and the loader/debug DMA port (m1). The winning request is
// registered and drives the memory for WAIT_STATES+1 cycles. Read data and a
// one-cycle ack are then returned to the winner. All outputs are registered.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties.
// Without it, m0 (the cpu) always wins a tie.
module mem_bus_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 1     // legal range 0..7
) (
  input  logic          clock,
  input  logic          reset,
  // requester 0: cpu fetch/load/store path
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  // requester 1: loader/debug DMA port
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  // returned read data, held until the next read completes
  output logic [DW-1:0] rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  state_e        state_q,     state_d;
  logic [2:0]    cnt_q,       cnt_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q,     rdata_d;
  logic          owner_q,     owner_d;
  logic          busy_q,      busy_d;
  logic          m0_ack_q,    m0_ack_d;
  logic          m1_ack_q,    m1_ack_d;

  logic          grant_any;
  logic          grant_m1;

  // Arbitration: decide which requester would win a grant this cycle.
  always_comb begin
    grant_any = m0_req | m1_req;
`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first.
    if (m0_req && m1_req) begin
      grant_m1 = ~owner_q;
    end else begin
      grant_m1 = m1_req;
    end
`else
    // The cpu path always wins a tie; m1 waits for a gap in m0 traffic.
    grant_m1 = m1_req & ~m0_req;
`endif
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/ACK sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          // Capture the winner's command; it stays frozen for the access.
          owner_d     = grant_m1;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_m1 ? m1_we    : m0_we;
          mem_addr_d  = grant_m1 ? m1_addr  : m0_addr;
          mem_wdata_d = grant_m1 ? m1_wdata : m0_wdata;
          cnt_d       = WAIT_CNT;
          busy_d      = 1'b1;
          state_d     = ST_ACCESS;
        end else begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Last access cycle: memory output is valid for the held address.
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = ST_ACK;
        end
      end

      ST_ACK: begin
        // Requests are ignored here so the requester can update them on the
        // ack edge without being re-granted stale values.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the address/data registers are reset too, not only the control
      // bits, because every output must read 0 while reset is applied.
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

  // Protocol invariants of the arbiter.
  a_ack_onehot : assert property (@(posedge clock) disable iff (reset)
    !(m0_ack_q && m1_ack_q));
  a_we_in_access : assert property (@(posedge clock) disable iff (reset)
    mem_we_q |-> (state_q == ST_ACCESS));
  a_we_needs_en : assert property (@(posedge clock) disable iff (reset)
    mem_we_q |-> mem_en_q);
  a_ack_in_ack : assert property (@(posedge clock) disable iff (reset)
    (m0_ack_q || m1_ack_q) |-> (state_q == ST_ACK));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Instance "a" runs with WAIT_STATES=1,
// instance "b" with WAIT_STATES=0. Each has a small combinational-read memory.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clock;
  logic reset;

  // instance a (WAIT_STATES = 1)
  logic          a_m0_req, a_m0_we, a_m0_ack;
  logic [AW-1:0] a_m0_addr;
  logic [DW-1:0] a_m0_wdata;
  logic          a_m1_req, a_m1_we, a_m1_ack;
  logic [AW-1:0] a_m1_addr;
  logic [DW-1:0] a_m1_wdata;
  logic [DW-1:0] a_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic          a_mem_en, a_mem_we, a_busy, a_owner;

  // instance b (WAIT_STATES = 0)
  logic          b_m0_req, b_m0_we, b_m0_ack;
  logic [AW-1:0] b_m0_addr;
  logic [DW-1:0] b_m0_wdata;
  logic          b_m1_req, b_m1_we, b_m1_ack;
  logic [AW-1:0] b_m1_addr;
  logic [DW-1:0] b_m1_wdata;
  logic [DW-1:0] b_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic          b_mem_en, b_mem_we, b_busy, b_owner;

  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(1)) dut_a (
    .clock(clock), .reset(reset),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_ack(a_m0_ack),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_ack(a_m1_ack),
    .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(0)) dut_b (
    .clock(clock), .reset(reset),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_ack(b_m1_ack),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models: combinational read, write on the falling edge while enabled.
  assign a_mem_rdata = mem_a[a_mem_addr[7:0]];
  assign b_mem_rdata = mem_b[b_mem_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 16'hA500 | 16'(i);
    mem_a[8'h10] = 16'hBEEF;
    forever begin
      @(negedge clock);
      if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:0]] = a_mem_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_b[i] = 16'hB500 | 16'(i);
    mem_b[8'h01] = 16'h1111;
    mem_b[8'h02] = 16'h2222;
    forever begin
      @(negedge clock);
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] = b_mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " rdata"},     32'(a_rdata),     32'h0);
    check({tag, " mem_en"},    32'(a_mem_en),    32'h0);
    check({tag, " mem_we"},    32'(a_mem_we),    32'h0);
    check({tag, " mem_addr"},  32'(a_mem_addr),  32'h0);
    check({tag, " mem_wdata"}, 32'(a_mem_wdata), 32'h0);
    check({tag, " m0_ack"},    32'(a_m0_ack),    32'h0);
    check({tag, " m1_ack"},    32'(a_m1_ack),    32'h0);
    check({tag, " busy"},      32'(a_busy),      32'h0);
    check({tag, " owner"},     32'(a_owner),     32'h0);
  endtask

  logic exp_m1 [3];

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_m1[0] = 1'b1; exp_m1[1] = 1'b0; exp_m1[2] = 1'b1;
`else
    exp_m1[0] = 1'b0; exp_m1[1] = 1'b0; exp_m1[2] = 1'b0;
`endif
    reset = 1'b1;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = '0; a_m0_wdata = '0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = '0; a_m1_wdata = '0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0; b_m1_wdata = '0;
    #2;
    check_a_zero("por");
    tick();
    reset = 1'b0;
    tick();

    // m0 read of 0x0010 (WAIT_STATES=1): mem_en cycles 1-2, ack cycle 3.
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 16'h0010;
    #1;
    check("rd c0 mem_en (no comb path)", 32'(a_mem_en), 32'h0);
    tick();
    check("rd c1 mem_en",   32'(a_mem_en),   32'h1);
    check("rd c1 mem_we",   32'(a_mem_we),   32'h0);
    check("rd c1 mem_addr", 32'(a_mem_addr), 32'h0010);
    check("rd c1 busy",     32'(a_busy),     32'h1);
    check("rd c1 m0_ack",   32'(a_m0_ack),   32'h0);
    tick();
    check("rd c2 mem_en",   32'(a_mem_en),   32'h1);
    check("rd c2 m0_ack",   32'(a_m0_ack),   32'h0);
    tick();
    check("rd c3 m0_ack",   32'(a_m0_ack),   32'h1);
    check("rd c3 m1_ack",   32'(a_m1_ack),   32'h0);
    check("rd c3 mem_en",   32'(a_mem_en),   32'h0);
    check("rd c3 rdata",    32'(a_rdata),    32'hBEEF);
    check("rd c3 busy",     32'(a_busy),     32'h1);
    a_m0_req = 0;
    tick();
    check("rd c4 m0_ack",   32'(a_m0_ack),   32'h0);
    check("rd c4 busy",     32'(a_busy),     32'h0);

    // m1 write 0x0020 <= 0x1234.
    a_m1_req = 1; a_m1_we = 1; a_m1_addr = 16'h0020; a_m1_wdata = 16'h1234;
    tick();
    check("wr c1 mem_we",    32'(a_mem_we),    32'h1);
    check("wr c1 mem_addr",  32'(a_mem_addr),  32'h0020);
    check("wr c1 mem_wdata", 32'(a_mem_wdata), 32'h1234);
    check("wr c1 owner",     32'(a_owner),     32'h1);
    tick();
    check("wr c2 mem_we",    32'(a_mem_we),    32'h1);
    tick();
    check("wr c3 m1_ack",    32'(a_m1_ack),    32'h1);
    check("wr c3 m0_ack",    32'(a_m0_ack),    32'h0);
    check("wr c3 mem_we",    32'(a_mem_we),    32'h0);
    check("wr c3 rdata kept", 32'(a_rdata),    32'hBEEF);
    a_m1_req = 0; a_m1_we = 0;
    tick();
    check("wr mem[0x20]",    32'(mem_a[8'h20]), 32'h1234);
    check("wr c4 m1_ack",    32'(a_m1_ack),    32'h0);

    // Reset asserted mid-cycle clears everything without waiting for a clock.
    #3;
    reset = 1'b1;
    #1;
    check_a_zero("midrst");
    tick();
    reset = 1'b0;
    tick();

    // Both requesters held high: three grants, one ack every 4 cycles.
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 16'h0040;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 16'h0041;
    for (int k = 0; k < 3; k++) begin
      tick(); tick(); tick();
      check($sformatf("tie%0d m1_ack", k), 32'(a_m1_ack), 32'(exp_m1[k]));
      check($sformatf("tie%0d m0_ack", k), 32'(a_m0_ack), 32'(!exp_m1[k]));
      check($sformatf("tie%0d owner", k),  32'(a_owner),  32'(exp_m1[k]));
      check($sformatf("tie%0d rdata", k),  32'(a_rdata),  exp_m1[k] ? 32'hA541 : 32'hA540);
      tick();
    end
    a_m0_req = 0; a_m1_req = 0;
    tick(); tick();
    check("tie idle busy", 32'(a_busy), 32'h0);

    // Reset in cycle 1 of an m0 write: strobe drops at once, no ack.
    a_m0_req = 1; a_m0_we = 1; a_m0_addr = 16'h0030; a_m0_wdata = 16'h5555;
    tick();
    check("abort c1 mem_we", 32'(a_mem_we), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("abort mem_we",  32'(a_mem_we), 32'h0);
    check("abort mem_en",  32'(a_mem_en), 32'h0);
    check("abort busy",    32'(a_busy),   32'h0);
    a_m0_req = 0; a_m0_we = 0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort post%0d m0_ack", k), 32'(a_m0_ack), 32'h0);
    end
    check("abort mem[0x30]", 32'(mem_a[8'h30]), 32'hA530);
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 16'h0010;
    tick(); tick(); tick();
    check("after abort m0_ack", 32'(a_m0_ack), 32'h1);
    check("after abort rdata",  32'(a_rdata),  32'hBEEF);
    a_m0_req = 0;
    tick();

    // WAIT_STATES=0: back-to-back m0 reads, acks in cycles 2 and 5.
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 16'h0001;
    tick();
    check("w0 c1 mem_en",   32'(b_mem_en),   32'h1);
    check("w0 c1 mem_addr", 32'(b_mem_addr), 32'h0001);
    tick();
    check("w0 c2 m0_ack",   32'(b_m0_ack),   32'h1);
    check("w0 c2 rdata",    32'(b_rdata),    32'h1111);
    check("w0 c2 mem_en",   32'(b_mem_en),   32'h0);
    b_m0_addr = 16'h0002;
    tick();
    check("w0 c3 m0_ack",   32'(b_m0_ack),   32'h0);
    check("w0 c3 mem_en",   32'(b_mem_en),   32'h0);
    tick();
    check("w0 c4 mem_en",   32'(b_mem_en),   32'h1);
    check("w0 c4 mem_addr", 32'(b_mem_addr), 32'h0002);
    check("w0 c4 m0_ack",   32'(b_m0_ack),   32'h0);
    tick();
    check("w0 c5 m0_ack",   32'(b_m0_ack),   32'h1);
    check("w0 c5 rdata",    32'(b_rdata),    32'h2222);
    check("w0 c5 m1_ack",   32'(b_m1_ack),   32'h0);
    b_m0_req = 0;
    tick();
    check("w0 c6 m0_ack",   32'(b_m0_ack),   32'h0);
    check("w0 c6 busy",     32'(b_busy),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
